win_energy_acc: RTL and testbench



---
 rtl/match_pkg.sv | 18 +
 rtl/win_energy_acc_if.sv | 35 +++
 rtl/win_energy_sq.sv | 45 ++++
 rtl/win_energy_acc.sv | 108 ++++++++++
 tb/tb_win_energy_acc.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/match_pkg.sv
// rtl/match_pkg.sv - shared Match-path types and widths for the window energy accumulator
package match_pkg;

  localparam int PIX_W_DEF   = 8;
  localparam int WIN_LEN_DEF = 64;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

  // Radical width: a full window of max-valued squares must fit without wrap.
  function automatic int acc_width(input int pix_w, input int win_len);
    return 2 * pix_w + $clog2(win_len);
  endfunction

endpackage

// File: rtl/win_energy_acc_if.sv
// rtl/win_energy_acc_if.sv - pixel-in / radical-out stream bundle; DIFF_MODE_EN adds in_ref_pix
interface win_energy_acc_if
  import match_pkg::*;
#(
  parameter int PIX_W   = PIX_W_DEF,
  parameter int WIN_LEN = WIN_LEN_DEF
);
  localparam int ACC_W = acc_width(PIX_W, WIN_LEN);
  localparam int CNT_W = $clog2(WIN_LEN + 1);

  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pix;
  logic             in_last;
`ifdef DIFF_MODE_EN
  logic [PIX_W-1:0] in_ref_pix;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_radical;
  logic [CNT_W-1:0] out_count;

`ifdef DIFF_MODE_EN
  modport master (output in_valid, in_pix, in_last, in_ref_pix, out_ready,
                  input  in_ready, out_valid, out_radical, out_count);
  modport slave  (input  in_valid, in_pix, in_last, in_ref_pix, out_ready,
                  output in_ready, out_valid, out_radical, out_count);
`else
  modport master (output in_valid, in_pix, in_last, out_ready,
                  input  in_ready, out_valid, out_radical, out_count);
  modport slave  (input  in_valid, in_pix, in_last, out_ready,
                  output in_ready, out_valid, out_radical, out_count);
`endif

endinterface

// File: rtl/win_energy_sq.sv
// rtl/win_energy_sq.sv - stage-1 squarer register with valid; DIFF_MODE_EN squares |pix - ref|
module win_energy_sq #(
  parameter int PIX_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               fire_i,
  input  logic [PIX_W-1:0]   pix_i,
`ifdef DIFF_MODE_EN
  input  logic [PIX_W-1:0]   ref_i,
`endif
  output logic [2*PIX_W-1:0] sq_o,
  output logic               sq_vld_o
);

  logic [PIX_W-1:0]   term;
  logic [2*PIX_W-1:0] term_ext;
  logic [2*PIX_W-1:0] sq_d, sq_q;
  logic               sq_vld_d, sq_vld_q;

  always_comb begin
`ifdef DIFF_MODE_EN
    term = (pix_i >= ref_i) ? (pix_i - ref_i) : (ref_i - pix_i);
`else
    term = pix_i;
`endif
    term_ext = {{PIX_W{1'b0}}, term};
    sq_d     = fire_i ? (term_ext * term_ext) : sq_q;
    sq_vld_d = fire_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sq_q     <= '0;
      sq_vld_q <= 1'b0;
    end else begin
      sq_q     <= sq_d;
      sq_vld_q <= sq_vld_d;
    end
  end

  assign sq_o     = sq_q;
  assign sq_vld_o = sq_vld_q;

endmodule

// File: rtl/win_energy_acc.sv
// rtl/win_energy_acc.sv - windowed sum-of-squares radical for the Match-path sqrt; DIFF_MODE_EN gives SSD
module win_energy_acc
  import match_pkg::*;
#(
  parameter int PIX_W   = PIX_W_DEF,
  parameter int WIN_LEN = WIN_LEN_DEF
) (
  input logic             clk_i,
  input logic             rst_i,
  win_energy_acc_if.slave bus
);
  localparam int ACC_W = acc_width(PIX_W, WIN_LEN);
  localparam int CNT_W = $clog2(WIN_LEN + 1);

  acc_state_e         state_d, state_q;
  logic [ACC_W-1:0]   acc_d, acc_q, acc_sum;
  logic [CNT_W-1:0]   cnt_d, cnt_q, cnt_inc;
  logic               in_ready_d, in_ready_q;
  logic               out_valid_d, out_valid_q;
  logic [ACC_W-1:0]   radical_d, radical_q;
  logic [CNT_W-1:0]   count_d, count_q;
  logic               fire, closing;
  logic [2*PIX_W-1:0] sq;
  logic               sq_vld;

  win_energy_sq #(.PIX_W(PIX_W)) u_sq (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .fire_i   (fire),
    .pix_i    (bus.in_pix),
`ifdef DIFF_MODE_EN
    .ref_i    (bus.in_ref_pix),
`endif
    .sq_o     (sq),
    .sq_vld_o (sq_vld)
  );

  always_comb begin
    fire    = bus.in_valid && in_ready_q;
    cnt_inc = cnt_q + CNT_W'(1);
    closing = fire && (bus.in_last || (cnt_inc == CNT_W'(WIN_LEN)));
    acc_sum = acc_q + (sq_vld ? ACC_W'(sq) : '0);

    state_d     = state_q;
    acc_d       = acc_sum;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    radical_d   = radical_q;
    count_d     = count_q;

    case (state_q)
      ACC: begin
        if (fire) cnt_d = cnt_inc;
        if (closing) begin
          state_d    = FLUSH;
          in_ready_d = 1'b0;
        end
      end
      // The closing beat's square lands in acc_sum this cycle.
      FLUSH: begin
        state_d     = HOLD;
        out_valid_d = 1'b1;
        radical_d   = acc_sum;
        count_d     = cnt_q;
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d     = ACC;
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d    = ACC;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      radical_q   <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      radical_q   <= radical_d;
      count_q     <= count_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_radical = radical_q;
  assign bus.out_count   = count_q;

endmodule

// File: tb/tb_win_energy_acc.sv
// tb/tb_win_energy_acc.sv - scoreboard bench for win_energy_acc; honours DIFF_MODE_EN
module tb_win_energy_acc;
  import match_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  win_energy_acc_if bus ();

  win_energy_acc dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rad;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int rad, input int cnt);
    exp_t e;
    e.rad = rad;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got radical %0d with no expectation", bus.out_radical);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_radical", 32'(bus.out_radical), e.rad);
        check("out_count", 32'(bus.out_count), e.cnt);
      end
    end
  end

  task automatic send(input logic [7:0] p, input logic [7:0] r, input logic last);
    int n;
    n = 0;
    @(negedge clk_i);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) check("in_ready_timeout", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_pix   = p;
    bus.in_last  = last;
`ifdef DIFF_MODE_EN
    bus.in_ref_pix = r;
`else
    if (r != 8'd0) $display("note: ref pixel %0d unused in this build", r);
`endif
    @(posedge clk_i);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(bus.in_ready && !bus.out_valid) && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("idle_reached", 32'(n < 100), 1);
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!bus.out_valid && n < 50);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_out_radical"}, 32'(bus.out_radical), 0);
    check({tag, "_out_count"}, 32'(bus.out_count), 0);
  endtask

  initial begin
    int n;
    int low;
    bus.in_valid  = 1'b0;
    bus.in_pix    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
`ifdef DIFF_MODE_EN
    bus.in_ref_pix = '0;
`endif
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    rst_i = 1'b0;

    // 1,2,3,4 with idle in_last=1 cycles in the middle that must be ignored
    push_exp(30, 4);
    send(8'd1, 8'd0, 1'b0);
    send(8'd2, 8'd0, 1'b0);
    bus.in_last = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    bus.in_last = 1'b0;
    send(8'd3, 8'd0, 1'b0);
    send(8'd4, 8'd0, 1'b1);
    wait_out_valid(n);
    check("latency", 32'(n), 2);

    // Full window auto-close at WIN_LEN
    wait_idle();
    push_exp(4161600, 64);
    for (int i = 0; i < 64; i++) send(8'd255, 8'd0, 1'b0);
    low = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (!bus.in_ready) low++;
    end
    check("in_ready_low_cycles", 32'(low), 2);

    // Early close, then a clean 1-pixel window
    push_exp(25, 2);
    send(8'd3, 8'd0, 1'b0);
    send(8'd4, 8'd0, 1'b1);
    push_exp(4, 1);
    send(8'd2, 8'd0, 1'b1);

    // Backpressure in HOLD for 5 cycles
    wait_idle();
    @(posedge clk_i);
    #1;
    bus.out_ready = 1'b0;
    push_exp(61, 2);
    send(8'd5, 8'd0, 1'b0);
    send(8'd6, 8'd0, 1'b1);
    wait_out_valid(n);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk_i);
      check("hold_out_valid", 32'(bus.out_valid), 1);
      check("hold_out_radical", 32'(bus.out_radical), 61);
      check("hold_out_count", 32'(bus.out_count), 2);
      check("hold_in_ready", 32'(bus.in_ready), 0);
      @(posedge clk_i);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk_i);
    #1;
    check("post_hs_in_ready", 32'(bus.in_ready), 1);
    check("post_hs_out_valid", 32'(bus.out_valid), 0);

    // Reset mid-window
    send(8'd100, 8'd0, 1'b0);
    send(8'd100, 8'd0, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    check_reset_outputs("rst_mid_window");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Reset mid-HOLD: the held radical is discarded
    bus.out_ready = 1'b0;
    send(8'd9, 8'd0, 1'b1);
    wait_out_valid(n);
    check("pre_rst_hold_valid", 32'(bus.out_valid), 1);
    #2;
    rst_i = 1'b1;
    #1;
    check_reset_outputs("rst_mid_hold");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    bus.out_ready = 1'b1;

    push_exp(4, 4);
    send(8'd1, 8'd0, 1'b0);
    send(8'd1, 8'd0, 1'b0);
    send(8'd1, 8'd0, 1'b0);
    send(8'd1, 8'd0, 1'b1);

`ifdef DIFF_MODE_EN
    push_exp(65043, 3);
    send(8'd10, 8'd7, 1'b0);
    send(8'd7, 8'd10, 1'b0);
    send(8'd0, 8'd255, 1'b1);
`else
    push_exp(149, 3);
    send(8'd10, 8'd0, 1'b0);
    send(8'd7, 8'd0, 1'b0);
    send(8'd0, 8'd0, 1'b1);
`endif

    wait_idle();
    repeat (2) @(negedge clk_i);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
